adder_pipe_seg: RTL and testbench

Parametrised, pipelined ripple-segment adder: the WIDTH-bit add is split into NSEG = WIDTH/SEG segments of SEG bits. Each segment's add happens in its own pipeline stage, with the carry registered between stages. It replaces the fixed 8/16/32-bit adder hierarchy wherever a registered, back-pressurable datapath adder is needed. It provides a full valid/ready handshake, carry-in and carry-out, and sustains one transaction per cycle.

---
 rtl/adder_pipe_seg.sv | 144 ++++++++++++++
 tb/tb_adder_pipe_seg.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_pipe_seg.sv
// adder_pipe_seg: pipelined ripple-segment adder. The WIDTH-bit add is split
// into NSEG = WIDTH/SEG stages of SEG bits, with the carry registered between
// stages and a valid/ready handshake that collapses bubbles.
// Optional feature macro: ADDER_PIPE_SUB_EN adds the `sub` input (a - b).
module adder_pipe_seg #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SEG   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef ADDER_PIPE_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned NSEG = WIDTH / SEG;

    if ((WIDTH % SEG) != 0) begin : g_bad_cfg
        $error("adder_pipe_seg: WIDTH must be a multiple of SEG");
    end

    // Per-stage state: valid, partial result, carry, skewed operand copies.
    logic [NSEG-1:0]  v_q, v_d;
    logic [NSEG-1:0]  c_q, c_d;
    logic [WIDTH-1:0] s_q [NSEG];
    logic [WIDTH-1:0] s_d [NSEG];
    logic [WIDTH-1:0] a_q [NSEG];
    logic [WIDTH-1:0] a_d [NSEG];
    logic [WIDTH-1:0] b_q [NSEG];
    logic [WIDTH-1:0] b_d [NSEG];

    // Upstream view of each stage: index 0 is the input port, index i is stage i-1.
    logic [NSEG-1:0]  up_v;
    logic [NSEG-1:0]  up_c;
    logic [WIDTH-1:0] up_s [NSEG];
    logic [WIDTH-1:0] up_a [NSEG];
    logic [WIDTH-1:0] up_b [NSEG];

    logic [NSEG:0]    rdy;
    logic [WIDTH-1:0] b_in;
    logic             cin_in;
    logic [SEG:0]     seg_sum;

    // Input conditioning; subtraction is folded into the operand at entry,
    // so the inverted b and forced carry travel down the skew registers.
    always_comb begin
        b_in   = b;
        cin_in = cin;
`ifdef ADDER_PIPE_SUB_EN
        if (sub) begin
            b_in   = ~b;
            cin_in = 1'b1;
        end
`endif
    end

    // Ready chain from the output back to the input: a stage can load when it
    // is empty or when the stage after it can load.
    always_comb begin
        rdy       = '0;
        rdy[NSEG] = out_ready;
        for (int unsigned k = 0; k < NSEG; k++) begin
            rdy[NSEG-1-k] = !v_q[NSEG-1-k] || rdy[NSEG-k];
        end
    end

    // Gather what each stage would load from its upstream neighbour.
    always_comb begin
        up_v    = '0;
        up_c    = '0;
        up_v[0] = in_valid;
        up_c[0] = cin_in;
        up_s[0] = '0;
        up_a[0] = a;
        up_b[0] = b_in;
        for (int unsigned k = 0; k + 1 < NSEG; k++) begin
            up_v[k+1] = v_q[k];
            up_c[k+1] = c_q[k];
            up_s[k+1] = s_q[k];
            up_a[k+1] = a_q[k];
            up_b[k+1] = b_q[k];
        end
    end

    // Next state: each loading stage adds its own segment; data only moves
    // with a valid transaction so idle stages keep their contents.
    always_comb begin
        v_d     = v_q;
        c_d     = c_q;
        s_d     = s_q;
        a_d     = a_q;
        b_d     = b_q;
        seg_sum = '0;
        for (int unsigned i = 0; i < NSEG; i++) begin
            seg_sum = {1'b0, up_a[i][i*SEG +: SEG]}
                    + {1'b0, up_b[i][i*SEG +: SEG]}
                    + (SEG+1)'(up_c[i]);
            if (rdy[i]) begin
                v_d[i] = up_v[i];
                if (up_v[i]) begin
                    s_d[i]               = up_s[i];
                    s_d[i][i*SEG +: SEG] = seg_sum[SEG-1:0];
                    c_d[i]               = seg_sum[SEG];
                    a_d[i]               = up_a[i];
                    b_d[i]               = up_b[i];
                end
            end
        end
    end

    // Stage registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q <= '0;
            c_q <= '0;
            for (int unsigned k = 0; k < NSEG; k++) begin
                s_q[k] <= '0;
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
        end else begin
            v_q <= v_d;
            c_q <= c_d;
            s_q <= s_d;
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = v_q[NSEG-1];
    assign sum       = s_q[NSEG-1];
    assign cout      = c_q[NSEG-1];

endmodule

// File: tb/tb_adder_pipe_seg.sv
// Bench for adder_pipe_seg: scoreboard of expected sums pushed on input
// transfer and popped on output transfer, plus directed latency, stall and
// reset scenarios. Define ADDER_PIPE_SUB_EN to also exercise subtraction.
module tb_adder_pipe_seg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned SEG   = 8;
    localparam int unsigned NSEG  = WIDTH / SEG;

    typedef struct {
        logic [WIDTH-1:0] s;
        logic             c;
        int               t;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;
    bit   chk_lat = 1'b0;
    bit   bp_rand = 1'b0;

    always #5 clk = ~clk;

    adder_pipe_seg #(.WIDTH(WIDTH), .SEG(SEG)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef ADDER_PIPE_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Whole-width reference add.
    function automatic exp_t model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                   input logic mc, input logic ms, input int t);
        exp_t         e;
        logic [WIDTH:0] r;
        r = {1'b0, ma} + {1'b0, mb} + (WIDTH+1)'(mc);
`ifdef ADDER_PIPE_SUB_EN
        if (ms) r = {1'b0, ma} + {1'b0, ~mb} + (WIDTH+1)'(1);
`endif
        e.s = r[WIDTH-1:0];
        e.c = r[WIDTH];
        e.t = t;
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Random output back-pressure when enabled.
    initial forever begin
        @(posedge clk);
        #1;
        if (bp_rand) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: all transfer decisions observed at the falling edge.
    initial begin
        exp_t             e;
        logic             prev_stall;
        logic [WIDTH-1:0] prev_sum;
        logic             prev_cout;
        prev_stall = 1'b0;
        prev_sum   = '0;
        prev_cout  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb.delete();
                prev_stall = 1'b0;
            end else begin
                if (prev_stall && out_valid) begin
                    check("hold_sum", sum, prev_sum);
                    check("hold_cout", cout, prev_cout);
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        check("spurious_out", out_valid, 0);
                    end else begin
                        e = sb.pop_front();
                        check("sum", sum, e.s);
                        check("cout", cout, e.c);
                        if (chk_lat) check("latency", cyc - e.t, NSEG);
                    end
                end
                if (in_valid && in_ready) sb.push_back(model(a, b, cin, sub, cyc));
                prev_stall = out_valid && !out_ready;
                prev_sum   = sum;
                prev_cout  = cout;
            end
        end
    end

    // Present one transaction and hold it until accepted; returns at posedge+1.
    task automatic send(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tbv,
                        input logic tc, input logic ts, output int waits);
        logic acc;
        a        = ta;
        b        = tbv;
        cin      = tc;
        sub      = ts;
        in_valid = 1'b1;
        waits    = 0;
        acc      = 1'b0;
        do begin
            @(negedge clk);
            acc = in_ready;
            waits++;
            @(posedge clk);
            #1;
        end while (!acc && waits < 200);
        if (!acc) check("send_timeout", in_ready, 1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
    endtask

    // Single transaction into an empty pipe with literal expected result.
    task automatic directed(input string tag, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tbv,
                            input logic tc, input logic ts,
                            input logic [WIDTH-1:0] es, input logic ec);
        int w;
        send(ta, tbv, tc, ts, w);
        in_valid = 1'b0;
        for (int k = 1; k <= int'(NSEG); k++) begin
            @(negedge clk);
            if (k < int'(NSEG)) begin
                check({tag, "_early"}, out_valid, 0);
            end else begin
                check({tag, "_valid"}, out_valid, 1);
                check({tag, "_sum"}, sum, es);
                check({tag, "_cout"}, cout, ec);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got %0d checks before time limit, expected completion", n_chk);
        $fatal(1, "time limit");
    end

    initial begin
        int               w;
        logic [WIDTH-1:0] x;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Carry ripples through every segment; then a carry across one boundary.
        chk_lat = 1'b1;
        directed("wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1);
        wait_drain();
        directed("seg_carry", 32'h0000_00FF, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_0101, 1'b0);
        wait_drain();

        // Back-to-back stream: one acceptance per cycle, fixed latency.
        for (int unsigned i = 0; i < 16; i++) begin
            x = WIDTH'(i) * 32'h0101_0101;
            send(x, ~x, 1'b1, 1'b0, w);
            check("stream_accept", w, 1);
        end
        in_valid = 1'b0;
        wait_drain();

        // Back-pressure: pipe fills to NSEG, then drains with no lost slot.
        chk_lat   = 1'b0;
        out_ready = 1'b0;
        for (int unsigned k = 0; k < NSEG; k++) begin
            a        = $urandom;
            b        = $urandom;
            cin      = k[0];
            sub      = 1'b0;
            in_valid = 1'b1;
            @(negedge clk);
            check("bp_accept", in_ready, 1);
            @(posedge clk);
            #1;
        end
        a   = $urandom;
        b   = $urandom;
        cin = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("bp_full_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_drain_slot", in_ready, 1);
        @(posedge clk);
        #1;
        a   = $urandom;
        b   = $urandom;
        cin = 1'b0;
        @(negedge clk);
        check("bp_drain_next", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_drain();

        // Random operands with random output back-pressure.
        bp_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            send($urandom, $urandom, 1'($urandom), 1'($urandom), w);
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b0;
        bp_rand  = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_drain();

        // Reset with three transactions in flight: none may emerge.
        for (int i = 0; i < 3; i++) begin
            send($urandom | 32'h1, $urandom | 32'h100, 1'b1, 1'b0, w);
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_valid", out_valid, 0);
        check("midrst_sum", sum, 0);
        check("midrst_cout", cout, 0);
        repeat (8) begin
            @(negedge clk);
            check("midrst_quiet", out_valid, 0);
        end
        @(posedge clk);
        #1;

        chk_lat = 1'b1;
        directed("post_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0);
        wait_drain();

`ifdef ADDER_PIPE_SUB_EN
        directed("sub_borrow", 32'd5, 32'd7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0);
        wait_drain();
        directed("sub_noborrow", 32'd7, 32'd5, 1'b0, 1'b1, 32'h0000_0002, 1'b1);
        wait_drain();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
